// File: rtl/picomips_ctrl.sv
// picoMIPS multi-cycle instruction controller: fetch handshake, decode, ALU control, flag register, branches.
// Build option: define PICO_MUL_EN to decode opcodes 9/10 as MUL; otherwise they retire as NOP and flag illegal_op.
//
// state  | meaning
// FETCH  | imem_req high, wait for imem_valid, capture the instruction word
// DECODE | rd_addr/rs_addr/imm driven for the register-file read
// EXEC   | ALU control, reg_we pulse, flag register and pc update
// HALT   | absorbing; only nReset leaves

module picomips_ctrl #(
   parameter int n = 8,
   localparam int IW = n + 10
) (
   input  logic          clk,
   input  logic          nReset,
   output logic          imem_req,
   output logic [n-1:0]  imem_addr,
   input  logic          imem_valid,
   input  logic [IW-1:0] imem_data,
   input  logic [3:0]    alu_flags,
   output logic [2:0]    alu_func,
   output logic [2:0]    rd_addr,
   output logic [2:0]    rs_addr,
   output logic [n-1:0]  imm,
   output logic          b_sel_imm,
   output logic          reg_we,
   output logic          halted,
   output logic          illegal_op
);

   localparam logic [2:0] RA = 3'd0, RB = 3'd1, RADD = 3'd2, RSUB = 3'd3;
   localparam logic [2:0] RAND = 3'd4, ROR = 3'd5, RXOR = 3'd6, MUL = 3'd7;

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

   state_t       state, state_nxt;
   logic [n-1:0] pc, pc_nxt;
   logic [3:0]   flags, flags_nxt;
   logic [3:0]   op, op_nxt;
   logic [2:0]   alu_func_nxt, rd_nxt, rs_nxt;
   logic [n-1:0] imm_nxt;
   logic         imem_req_nxt, b_sel_nxt, reg_we_nxt, halted_nxt, illegal_nxt;
   logic         taken;

   function automatic logic writes_flags(input logic [3:0] o);
`ifdef PICO_MUL_EN
      return (o >= 4'd2) && (o <= 4'd10);
`else
      return (o >= 4'd2) && (o <= 4'd8);
`endif
   endfunction

   assign imem_addr = pc;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state      <= S_FETCH;
         pc         <= '0;
         flags      <= '0;
         op         <= '0;
         imem_req   <= 1'b1;
         alu_func   <= RA;
         rd_addr    <= '0;
         rs_addr    <= '0;
         imm        <= '0;
         b_sel_imm  <= 1'b0;
         reg_we     <= 1'b0;
         halted     <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         flags      <= flags_nxt;
         op         <= op_nxt;
         imem_req   <= imem_req_nxt;
         alu_func   <= alu_func_nxt;
         rd_addr    <= rd_nxt;
         rs_addr    <= rs_nxt;
         imm        <= imm_nxt;
         b_sel_imm  <= b_sel_nxt;
         reg_we     <= reg_we_nxt;
         halted     <= halted_nxt;
         illegal_op <= illegal_nxt;
      end
   end

   // Outputs are computed for the state being entered, so every output is a flop.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      flags_nxt    = flags;
      op_nxt       = op;
      rd_nxt       = rd_addr;
      rs_nxt       = rs_addr;
      imm_nxt      = imm;
      imem_req_nxt = 1'b0;
      alu_func_nxt = RA;
      b_sel_nxt    = 1'b0;
      reg_we_nxt   = 1'b0;
      halted_nxt   = 1'b0;
      illegal_nxt  = 1'b0;
      taken        = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req_nxt = 1'b1;
            if (imem_valid) begin
               op_nxt       = imem_data[IW-1 -: 4];
               rd_nxt       = imem_data[IW-5 -: 3];
               rs_nxt       = imem_data[IW-8 -: 3];
               imm_nxt      = imem_data[n-1:0];
               imem_req_nxt = 1'b0;
               state_nxt    = S_DECODE;
            end
         end
         S_DECODE: begin
            state_nxt = S_EXEC;
            case (op)
               4'd1:  begin alu_func_nxt = RB;   b_sel_nxt = 1'b1; reg_we_nxt = 1'b1; end
               4'd2:  begin alu_func_nxt = RADD; reg_we_nxt = 1'b1; end
               4'd3:  begin alu_func_nxt = RADD; b_sel_nxt = 1'b1; reg_we_nxt = 1'b1; end
               4'd4:  begin alu_func_nxt = RSUB; reg_we_nxt = 1'b1; end
               4'd5:  begin alu_func_nxt = RSUB; b_sel_nxt = 1'b1; reg_we_nxt = 1'b1; end
               4'd6:  begin alu_func_nxt = RAND; reg_we_nxt = 1'b1; end
               4'd7:  begin alu_func_nxt = ROR;  reg_we_nxt = 1'b1; end
               4'd8:  begin alu_func_nxt = RXOR; reg_we_nxt = 1'b1; end
`ifdef PICO_MUL_EN
               4'd9:  begin alu_func_nxt = MUL;  reg_we_nxt = 1'b1; end
               4'd10: begin alu_func_nxt = MUL;  b_sel_nxt = 1'b1; reg_we_nxt = 1'b1; end
`else
               4'd9, 4'd10: illegal_nxt = 1'b1;
`endif
               default: ;
            endcase
         end
         S_EXEC: begin
            state_nxt    = S_FETCH;
            imem_req_nxt = 1'b1;
            if (writes_flags(op)) flags_nxt = alu_flags;
            case (op)
               4'd11:   taken = flags[1];
               4'd12:   taken = ~flags[1];
               4'd13:   taken = flags[0];
               4'd14:   taken = flags[2];
               default: taken = 1'b0;
            endcase
            pc_nxt = taken ? pc + imm : pc + 1'b1;
            if (op == 4'd15) begin
               state_nxt    = S_HALT;
               pc_nxt       = pc;
               imem_req_nxt = 1'b0;
               halted_nxt   = 1'b1;
            end
         end
         S_HALT: halted_nxt = 1'b1;
         default: state_nxt = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_picomips_ctrl.sv
// Self-checking bench for picomips_ctrl: the bench plays program memory and the ALU flag source,
// and an instruction-level reference model supplies the expected outputs for every cycle.

module tb_picomips_ctrl;
   localparam int N  = 8;
   localparam int IW = N + 10;

   logic          clk = 1'b0;
   logic          nReset = 1'b0;
   logic          imem_req;
   logic [N-1:0]  imem_addr;
   logic          imem_valid = 1'b0;
   logic [IW-1:0] imem_data = '0;
   logic [3:0]    alu_flags = '0;
   logic [2:0]    alu_func, rd_addr, rs_addr;
   logic [N-1:0]  imm;
   logic          b_sel_imm, reg_we, halted, illegal_op;

   picomips_ctrl #(.n(N)) dut (
      .clk(clk), .nReset(nReset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data), .alu_flags(alu_flags),
      .alu_func(alu_func), .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm),
      .b_sel_imm(b_sel_imm), .reg_we(reg_we), .halted(halted), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: architectural state plus last decoded fields
   logic [N-1:0] m_pc;
   logic [3:0]   m_flags;
   logic [2:0]   m_rd, m_rs;
   logic [N-1:0] m_imm;

   // expected outputs for the current cycle
   bit           chk_en = 0;
   logic         e_req, e_bsel, e_we, e_halted, e_ill;
   logic [N-1:0] e_addr, e_imm;
   logic [2:0]   e_func, e_rd, e_rs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req",   32'(imem_req),   32'(e_req));
         chk("imem_addr",  32'(imem_addr),  32'(e_addr));
         chk("alu_func",   32'(alu_func),   32'(e_func));
         chk("rd_addr",    32'(rd_addr),    32'(e_rd));
         chk("rs_addr",    32'(rs_addr),    32'(e_rs));
         chk("imm",        32'(imm),        32'(e_imm));
         chk("b_sel_imm",  32'(b_sel_imm),  32'(e_bsel));
         chk("reg_we",     32'(reg_we),     32'(e_we));
         chk("halted",     32'(halted),     32'(e_halted));
         chk("illegal_op", 32'(illegal_op), 32'(e_ill));
      end
   end

   task automatic set_idle(input logic req, input logic hlt);
      e_req = req; e_addr = m_pc; e_func = 3'd0; e_rd = m_rd; e_rs = m_rs; e_imm = m_imm;
      e_bsel = 1'b0; e_we = 1'b0; e_halted = hlt; e_ill = 1'b0;
   endtask

   // Instruction set semantics: ALU code (RA=0,RB=1,RADD=2,RSUB=3,RAND=4,ROR=5,RXOR=6,MUL=7)
   task automatic op_semantics(input logic [3:0] op, output logic [2:0] f, output logic bs,
                               output logic we, output logic ill, output logic upd);
      f = 3'd0; bs = 1'b0; we = 1'b0; ill = 1'b0; upd = 1'b0;
      case (op)
         4'd1:  begin f = 3'd1; bs = 1'b1; we = 1'b1; end
         4'd2:  begin f = 3'd2; we = 1'b1; upd = 1'b1; end
         4'd3:  begin f = 3'd2; bs = 1'b1; we = 1'b1; upd = 1'b1; end
         4'd4:  begin f = 3'd3; we = 1'b1; upd = 1'b1; end
         4'd5:  begin f = 3'd3; bs = 1'b1; we = 1'b1; upd = 1'b1; end
         4'd6:  begin f = 3'd4; we = 1'b1; upd = 1'b1; end
         4'd7:  begin f = 3'd5; we = 1'b1; upd = 1'b1; end
         4'd8:  begin f = 3'd6; we = 1'b1; upd = 1'b1; end
`ifdef PICO_MUL_EN
         4'd9:  begin f = 3'd7; we = 1'b1; upd = 1'b1; end
         4'd10: begin f = 3'd7; bs = 1'b1; we = 1'b1; upd = 1'b1; end
`else
         4'd9, 4'd10: ill = 1'b1;
`endif
         default: ;
      endcase
   endtask

   function automatic logic branch_taken(input logic [3:0] op, input logic [3:0] fl);
      // fl = {V,N,Z,C}
      case (op)
         4'd11:   return fl[1];
         4'd12:   return !fl[1];
         4'd13:   return fl[0];
         4'd14:   return fl[2];
         default: return 1'b0;
      endcase
   endfunction

   task automatic do_reset();
      chk_en = 0;
      nReset = 1'b0;
      imem_valid = 1'b0;
      #2;
      chk("rst imem_addr",  32'(imem_addr),  32'h0);
      chk("rst alu_func",   32'(alu_func),   32'h0);
      chk("rst rd_addr",    32'(rd_addr),    32'h0);
      chk("rst rs_addr",    32'(rs_addr),    32'h0);
      chk("rst imm",        32'(imm),        32'h0);
      chk("rst b_sel_imm",  32'(b_sel_imm),  32'h0);
      chk("rst reg_we",     32'(reg_we),     32'h0);
      chk("rst halted",     32'(halted),     32'h0);
      chk("rst illegal_op", 32'(illegal_op), 32'h0);
      @(posedge clk); #1;
      nReset = 1'b1;
      m_pc = '0; m_flags = '0; m_rd = '0; m_rs = '0; m_imm = '0;
      set_idle(1'b1, 1'b0);
      chk_en = 1;
   endtask

   // Called one step after a clock edge with the controller in FETCH.
   task automatic do_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [N-1:0] im, input int waits, input logic [3:0] fl,
                           input bit abort);
      logic [2:0] f;
      logic bs, we, ill, upd;
      for (int w = 0; w < waits; w++) begin
         imem_valid = 1'b0;
         imem_data  = IW'($urandom);
         alu_flags  = 4'($urandom);
         set_idle(1'b1, 1'b0);
         @(posedge clk); #1;
      end
      imem_valid = 1'b1;
      imem_data  = {op, rd, rs, im};
      alu_flags  = 4'($urandom);
      set_idle(1'b1, 1'b0);
      @(posedge clk); #1;
      imem_valid = 1'($urandom);
      imem_data  = IW'($urandom);
      alu_flags  = 4'($urandom);
      m_rd = rd; m_rs = rs; m_imm = im;
      set_idle(1'b0, 1'b0);
      @(posedge clk); #1;
      op_semantics(op, f, bs, we, ill, upd);
      set_idle(1'b0, 1'b0);
      e_func = f; e_bsel = bs; e_we = we; e_ill = ill;
      imem_valid = 1'($urandom);
      alu_flags  = fl;
      if (abort) begin
         #2;
         chk_en = 0;
         nReset = 1'b0;
         #1;
         chk("abort imem_addr", 32'(imem_addr), 32'h0);
         chk("abort reg_we",    32'(reg_we),    32'h0);
         do_reset();
      end else begin
         @(posedge clk); #1;
         if (op == 4'd15) begin
            set_idle(1'b0, 1'b1);
         end else begin
            m_pc = branch_taken(op, m_flags) ? m_pc + im : m_pc + 1'b1;
            if (upd) m_flags = fl;
            set_idle(1'b1, 1'b0);
         end
      end
   endtask

   task automatic halt_hold(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         imem_valid = 1'($urandom);
         imem_data  = IW'($urandom);
         alu_flags  = 4'($urandom);
         @(posedge clk); #1;
      end
      chk("halt imem_req", 32'(imem_req), 32'h0);
      chk("halt halted",   32'(halted),   32'h1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("post-reset imem_req", 32'(imem_req), 32'h1);

      // ADDI r1,0x05 with immediate valid
      do_instr(4'd3, 3'd1, 3'd0, 8'h05, 0, 4'h0, 0);
      chk("addi pc", 32'(imem_addr), 32'h01);

      // SUB sets Z, BEQ -4 at 0x11 taken
      do_reset();
      do_instr(4'd12, 3'd0, 3'd0, 8'h10, 0, 4'h0, 0);
      do_instr(4'd4, 3'd2, 3'd3, 8'h00, 0, 4'b0010, 0);
      chk("sub pc", 32'(imem_addr), 32'h11);
      do_instr(4'd11, 3'd0, 3'd0, 8'hFC, 0, 4'h0, 0);
      chk("beq taken pc", 32'(imem_addr), 32'h0D);

      do_reset();
      do_instr(4'd12, 3'd0, 3'd0, 8'h10, 1, 4'hF, 0);
      do_instr(4'd4, 3'd2, 3'd3, 8'h00, 0, 4'b0000, 0);
      do_instr(4'd11, 3'd0, 3'd0, 8'hFC, 0, 4'hF, 0);
      chk("beq not taken pc", 32'(imem_addr), 32'h12);

      // MOVI must not clear N from the preceding ADD
      do_reset();
      do_instr(4'd2, 3'd1, 3'd2, 8'h00, 0, 4'b1100, 0);
      do_instr(4'd1, 3'd3, 3'd0, 8'h7E, 0, 4'b0000, 0);
      do_instr(4'd14, 3'd0, 3'd0, 8'h03, 0, 4'h0, 0);
      chk("bmi taken pc", 32'(imem_addr), 32'h05);

      // four wait cycles in FETCH
      do_instr(4'd6, 3'd4, 3'd5, 8'hA5, 4, 4'h3, 0);
      chk("wait instr pc", 32'(imem_addr), 32'h06);

      // pc wrap via branch at 0xFF, then HALT
      do_reset();
      do_instr(4'd12, 3'd0, 3'd0, 8'hFF, 0, 4'h0, 0);
      chk("jump to ff", 32'(imem_addr), 32'hFF);
      do_instr(4'd12, 3'd0, 3'd0, 8'h01, 2, 4'h2, 0);
      chk("wrap pc", 32'(imem_addr), 32'h00);
      do_instr(4'd15, 3'd0, 3'd0, 8'h00, 0, 4'h0, 0);
      halt_hold(10);
      chk("halt pc held", 32'(imem_addr), 32'h00);

      // reset during EXEC abandons the instruction
      do_reset();
      do_instr(4'd12, 3'd0, 3'd0, 8'h40, 0, 4'h0, 0);
      do_instr(4'd2, 3'd1, 3'd1, 8'h00, 0, 4'hF, 1);
      do_instr(4'd0, 3'd0, 3'd0, 8'h00, 0, 4'h0, 0);
      chk("after abort pc", 32'(imem_addr), 32'h01);

      // MUL at 0x20, then BEQ reveals whether flags were loaded
      do_reset();
      do_instr(4'd12, 3'd0, 3'd0, 8'h20, 0, 4'h0, 0);
      do_instr(4'd9, 3'd1, 3'd2, 8'h00, 0, 4'b1111, 0);
      chk("mul pc", 32'(imem_addr), 32'h21);
      do_instr(4'd11, 3'd0, 3'd0, 8'h10, 0, 4'h0, 0);
`ifdef PICO_MUL_EN
      chk("post-mul beq pc", 32'(imem_addr), 32'h31);
`else
      chk("post-mul beq pc", 32'(imem_addr), 32'h22);
`endif

      // randomized program
      do_reset();
      for (int i = 0; i < 300; i++) begin
         do_instr(4'($urandom_range(0, 14)), 3'($urandom), 3'($urandom), N'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                  4'($urandom), 0);
      end
      do_instr(4'd15, 3'($urandom), 3'($urandom), N'($urandom), 1, 4'($urandom), 0);
      halt_hold(6);

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
